// File: rtl/spi_clgen_mode.sv
// SPI serial-clock generator and transfer sequencer: latches a per-transfer
// configuration, produces SCLK in any SPI mode with resolved sample/shift strobes.
module spi_clgen_mode #(
  parameter int unsigned DIVIDER_LEN = 8,
  parameter int unsigned CNT_LEN     = 7
) (
  input  logic                   wb_clk_in,
  input  logic                   wb_rst_n,
  input  logic                   go,
  input  logic                   abort,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [DIVIDER_LEN-1:0] divider,
  input  logic [CNT_LEN-1:0]     char_len,
  output logic                   sclk_out,
  output logic                   pos_edge,
  output logic                   neg_edge,
  output logic                   sample,
  output logic                   shift,
  output logic                   last_clk,
  output logic                   tip,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, TRAIL, DONE} state_e;

  localparam logic [DIVIDER_LEN-1:0] DIV_ONE  = {{(DIVIDER_LEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_LEN:0]       EDGE_ONE = {{CNT_LEN{1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [DIVIDER_LEN-1:0] cnt_q, cnt_d;
  logic [DIVIDER_LEN-1:0] div_q, div_d;
  logic [CNT_LEN-1:0]     len_q, len_d;
  logic [CNT_LEN:0]       edge_q, edge_d;
  logic                   cpha_q, cpha_d;
  logic                   sclk_q, sclk_d;

  logic             edge_now;
  logic             leading;
  logic             last_edge;
  logic [CNT_LEN:0] final_idx;

  // 2N-1; a zero length wraps naturally to the all-ones index of 2^CNT_LEN bits
  assign final_idx = {len_q, 1'b0} - EDGE_ONE;
  assign last_edge = (edge_q == final_idx);
  assign leading   = ~edge_q[0];
  assign edge_now  = (state_q == ACTIVE) && (cnt_q == '0) && !abort;

  always_ff @(posedge wb_clk_in) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      len_q   <= '0;
      edge_q  <= '0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      len_q   <= len_d;
      edge_q  <= edge_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    len_d   = len_q;
    edge_d  = edge_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    unique case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (go && !abort) begin
          state_d = ACTIVE;
          cnt_d   = divider;
          div_d   = divider;
          len_d   = char_len;
          cpha_d  = cpha;
          edge_d  = '0;
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_d = IDLE;
          sclk_d  = cpol;
        end else if (cnt_q == '0) begin
          cnt_d  = div_q;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_ONE;
          if (last_edge) state_d = TRAIL;
        end else begin
          cnt_d = cnt_q - DIV_ONE;
        end
      end
      TRAIL: begin
        if (abort) begin
          state_d = IDLE;
          sclk_d  = cpol;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - DIV_ONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge outputs are visible in the same cycle the half-period counter hits zero
  assign sclk_out = sclk_q ^ edge_now;
  assign pos_edge = edge_now & ~sclk_q;
  assign neg_edge = edge_now & sclk_q;
  assign sample   = edge_now & (cpha_q ? ~leading : leading);
  assign shift    = edge_now & (cpha_q ? leading : (~leading & ~last_edge));
  assign last_clk = edge_now & last_edge;
  assign tip      = (state_q == ACTIVE) || (state_q == TRAIL);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_spi_clgen_mode.sv
// Bench for spi_clgen_mode: directed scenarios plus random traffic, compared
// cycle by cycle against an arithmetic model of the transfer timeline.
module tb_spi_clgen_mode;

  logic       clk = 1'b0;
  logic       rst_n, go, abort, cpol, cpha;
  logic [7:0] divider;
  logic [6:0] char_len;
  logic       sclk_out, pos_edge, neg_edge, sample, shift, last_clk, tip, done;

  spi_clgen_mode #(.DIVIDER_LEN(8), .CNT_LEN(7)) dut (
    .wb_clk_in(clk), .wb_rst_n(rst_n), .go(go), .abort(abort), .cpol(cpol),
    .cpha(cpha), .divider(divider), .char_len(char_len), .sclk_out(sclk_out),
    .pos_edge(pos_edge), .neg_edge(neg_edge), .sample(sample), .shift(shift),
    .last_clk(last_clk), .tip(tip), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int scn    = 0;

  // model state: m_t is the cycle index within a transfer, 0 when idle
  int   m_t = 0, m_div = 0, m_n = 1;
  logic m_cpol = 1'b0, m_cpha = 1'b0, m_idle = 1'b0;
  logic p_rst = 1'b0, pp_rst = 1'b0, p_go = 1'b0, p_abort = 1'b0, p_abort_xfer = 1'b0;
  int   p_mt = 0;

  logic [63:0] rise_m, fall_m, samp_m, shft_m;
  int n_tip, n_edges, n_samp, t_last, t_done;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int d1, tn, tt, k, i, e;
    logic ed, lead;
    logic [7:0] exp_v, got_v;
    got_v = {sclk_out, pos_edge, neg_edge, sample, shift, last_clk, tip, done};
    d1 = m_div + 1;
    tn = 2 * m_n;
    tt = (tn + 1) * d1;
    exp_v = '0;
    if (m_t == 0) begin
      exp_v[7] = m_idle;
    end else if (m_t <= tt) begin
      k  = m_t / d1;
      ed = (m_t % d1 == 0) && (k >= 1) && (k <= tn);
      e  = (k > tn) ? tn : k;
      if (ed && abort) e = e - 1;
      exp_v[7] = m_cpol ^ e[0];
      exp_v[1] = 1'b1;
      if (ed && !abort) begin
        i = k - 1;
        lead = (i % 2 == 0);
        exp_v[6] = exp_v[7];
        exp_v[5] = !exp_v[7];
        if (m_cpha) begin
          exp_v[3] = lead;
          exp_v[4] = !lead;
        end else begin
          exp_v[4] = lead;
          exp_v[3] = !lead && (i != tn - 1);
        end
        exp_v[2] = (i == tn - 1);
      end
    end else begin
      exp_v[7] = m_cpol;
      exp_v[0] = 1'b1;
    end
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_model t=%0d scn=%0d: got %b expected %b (sclk,pos,neg,smp,shf,last,tip,done)",
               m_t, scn, got_v, exp_v);
    end

    // per-transfer log of what the DUT actually produced
    if (m_t == 1) begin
      rise_m = '0; fall_m = '0; samp_m = '0; shft_m = '0;
      n_tip = 0; n_edges = 0; n_samp = 0; t_last = 0; t_done = 0;
    end
    if (m_t > 0) begin
      if (m_t < 64) begin
        rise_m[m_t] = pos_edge; fall_m[m_t] = neg_edge;
        samp_m[m_t] = sample;   shft_m[m_t] = shift;
      end
      n_tip   += int'(tip);
      n_edges += int'(pos_edge | neg_edge);
      n_samp  += int'(sample);
      if (last_clk) t_last = m_t;
      if (done) t_done = m_t;
    end

    if (m_t != 0 && m_t == tt + 1) begin
      case (scn)
        1: begin
          chk("m0_tip_len", n_tip, 10);  chk("m0_rise", rise_m, 64'h44);
          chk("m0_fall", fall_m, 64'h110); chk("m0_sample", samp_m, 64'h44);
          chk("m0_shift", shft_m, 64'h10); chk("m0_last", t_last, 8);
          chk("m0_done", t_done, 11);
        end
        2: begin
          chk("m3_idle_lvl", sclk_out, 1); chk("m3_fall", fall_m, 64'h2A);
          chk("m3_rise", rise_m, 64'h54);  chk("m3_shift", shft_m, 64'h2A);
          chk("m3_sample", samp_m, 64'h54); chk("m3_last", t_last, 6);
          chk("m3_done", t_done, 8);
        end
        3: begin
          chk("max_edges", n_edges, 256); chk("max_samples", n_samp, 128);
          chk("max_last", t_last, 256);   chk("max_done", t_done, 258);
        end
        7: begin
          chk("ign_last", t_last, 18); chk("ign_done", t_done, 22);
          chk("ign_tip_len", n_tip, 21);
        end
        8: begin
          chk("post_abort_last", t_last, 64); chk("post_abort_done", t_done, 69);
          chk("post_abort_samples", n_samp, 8);
        end
        default: ;
      endcase
    end

    if (!p_rst) chk("reset_outputs", got_v, 0);
    if (scn == 6 && !pp_rst && p_rst) chk("reset_release_sclk", sclk_out, 1);
    if (scn == 4 && p_abort_xfer) begin
      chk("abort_tip", tip, 0); chk("abort_sclk", sclk_out, 0); chk("abort_done", done, 0);
    end
    if (scn == 5 && p_go && p_abort && p_mt == 0 && p_rst) chk("go_abort_idle_tip", tip, 0);

    // advance the model with the inputs the DUT samples at the next edge
    p_abort_xfer = rst_n && abort && m_t >= 1 && m_t <= tt;
    pp_rst = p_rst; p_rst = rst_n; p_go = go; p_abort = abort; p_mt = m_t;
    if (!rst_n) begin
      m_t = 0; m_idle = 1'b0;
    end else if (m_t == 0) begin
      if (go && !abort) begin
        m_t = 1; m_cpol = cpol; m_cpha = cpha; m_div = int'(divider);
        m_n = (char_len == 0) ? 128 : int'(char_len);
      end else m_idle = cpol;
    end else if (m_t <= tt) begin
      if (abort) begin m_t = 0; m_idle = cpol; end
      else m_t = m_t + 1;
    end else begin
      m_t = 0; m_idle = m_cpol;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic pol, input logic pha, input int dv, input int ln);
    cpol = pol; cpha = pha; divider = 8'(dv); char_len = 7'(ln);
  endtask

  task automatic start();
    go = 1'b1; tick(); go = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0;
    cfg(1'b0, 1'b0, 0, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    scn = 1; cfg(1'b0, 1'b0, 1, 2); tick(); start(); repeat (14) tick();
    scn = 2; cfg(1'b1, 1'b1, 0, 3); repeat (2) tick(); start(); repeat (10) tick();
    scn = 3; cfg(1'b0, 1'b0, 0, 0); repeat (2) tick(); start(); repeat (262) tick();

    scn = 4; cfg(1'b0, 1'b0, 3, 8); tick(); start();
    repeat (9) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (5) tick();
    scn = 8; start(); repeat (75) tick();

    scn = 5; go = 1'b1; abort = 1'b1; tick(); go = 1'b0; abort = 1'b0; repeat (3) tick();

    scn = 7; cfg(1'b0, 1'b0, 2, 3); tick(); start();
    repeat (20) begin
      cfg(1'($urandom), 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
      go = 1'($urandom);
      tick();
    end
    go = 1'b0; cfg(1'b0, 1'b0, 2, 3);
    repeat (5) tick();

    scn = 6; cfg(1'b1, 1'b0, 1, 4); repeat (2) tick(); start();
    repeat (4) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (4) tick();

    scn = 0;
    repeat (4000) begin
      cfg(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
          ($urandom % 40 == 0) ? 0 : int'($urandom_range(1, 5)));
      go    = ($urandom % 4 == 0);
      abort = ($urandom % 80 == 0);
      rst_n = ($urandom % 700 != 0);
      tick();
    end
    rst_n = 1'b1; go = 1'b0; abort = 1'b0;
    repeat (1100) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_clgen_mode.md
# spi_clgen_mode

Parametrised SPI serial-clock generator and transfer sequencer. It is the successor to `spi_clgen` and sits between the SPI register file and the shift register. It latches a per-transfer configuration: divider, CPOL, CPHA and character length. It produces `sclk_out` in any of the four SPI modes, along with mode-resolved sample/shift strobes. It also counts edges, so `last_clk` and `tip` are generated internally instead of being supplied by the shift register.

## Interface
Parameters:
- `DIVIDER_LEN`, 8, width of the `divider` input.
- `CNT_LEN`, 7, width of `char_len`. The maximum character length is 2^`CNT_LEN` bits.

Ports:
- `wb_clk_in`  in  1  Wishbone clock. All logic is on its rising edge.
- `wb_rst_n`  in  1  Reset. Synchronous, active-low.
- `go`  in  1  Start request. Sampled only in IDLE.
- `abort`  in  1  Terminate the current transfer.
- `cpol`  in  1  Clock idle level.
- `cpha`  in  1  0: sample on the leading edge. 1: sample on the trailing edge.
- `divider`  in  `DIVIDER_LEN`  Half-period minus one, in `wb_clk_in` cycles.
- `char_len`  in  `CNT_LEN`  Bits per transfer. 0 means 2^`CNT_LEN`.
- `sclk_out`  out  1  Serial clock.
- `pos_edge`  out  1  One-cycle pulse in the cycle `sclk_out` becomes 1.
- `neg_edge`  out  1  One-cycle pulse in the cycle `sclk_out` becomes 0.
- `sample`  out  1  Strobe: capture MISO.
- `shift`  out  1  Strobe: advance MOSI.
- `last_clk`  out  1  Pulse coincident with the final SCLK edge.
- `tip`  out  1  Transfer in progress.
- `done`  out  1  One-cycle completion pulse.

## Operation
States and transitions:
- IDLE:
  - `tip`=0.
  - `sclk_out` is a registered copy of the live `cpol` input, with 1-cycle lag.
  - `go`=1 latches `cpol`, `cpha`, `divider` and `char_len`, loads the half-period counter with `divider`, clears the edge counter, then moves to ACTIVE.
- ACTIVE:
  - The half-period counter decrements each cycle.
  - When the counter reaches 0: reload it with the latched divider, toggle `sclk_out`, and increment the edge counter.
  - Edge index i runs 0..2N-1, where N is the latched bit count (`char_len`, with 0 meaning 2^`CNT_LEN`). Even i is a leading edge; odd i is a trailing edge.
  - Leaving ACTIVE: after edge 2N-1, go to TRAIL. `sclk_out` is then back at the latched `cpol`.
- TRAIL: hold `sclk_out` for one half-period (`divider`+1 cycles), then go to DONE.
- DONE: one cycle with `done`=1 and `tip`=0, then return to IDLE.

Strobe resolution:
- `cpha`=0:
  - `sample` on leading edges.
  - `shift` on trailing edges, except the final edge. The first bit is presented by the shift register at `go`.
- `cpha`=1:
  - `shift` on every leading edge.
  - `sample` on every trailing edge.
- `pos_edge`/`neg_edge` fire according to the direction of the toggle, independent of `cpha`.
- `last_clk` is asserted only on edge 2N-1.

Configuration, arithmetic and boundary rules:
- Configuration inputs are ignored outside IDLE. `go` is ignored outside IDLE.
- Counters wrap-free: the edge counter is `CNT_LEN`+1 bits wide. For N=2^`CNT_LEN`, the final edge index is 2^(`CNT_LEN`+1)-1.
- `abort`=1 in ACTIVE or TRAIL: on the next cycle go to IDLE, `tip`=0, `sclk_out` at the live `cpol`. No `done` pulse and no strobes are generated.
- `abort` and `go` together in IDLE: `abort` wins and the block stays in IDLE.
- `abort` in DONE: ignored; `done` still pulses.

Reset (`wb_rst_n`=0 at a clock edge, from any state):
- Next cycle: IDLE, `sclk_out`=0, and all strobes, `tip` and `done` at 0.
- The first cycle after release, `sclk_out` follows `cpol`.

## Timing
- Let t=1 be the first cycle with `tip`=1. This is the cycle after `go` is sampled in IDLE.
- Edge i is at t=(i+1)·(`divider`+1). `sclk_out` changes and its strobes are high in that same cycle.
- `tip`=1 for exactly (2N+1)·(`divider`+1) cycles.
- `done`=1 at t=(2N+1)·(`divider`+1)+1.
- A new `go` is accepted in the cycle after `done`.
- `divider`=0 gives `sclk_out` at f/2, with a strobe every cycle. This is legal.
- Strobes never overlap: at most one of `pos_edge`/`neg_edge` per cycle, and at most one of `sample`/`shift` per cycle.

## Test plan
- Mode 0, `divider`=1, `char_len`=2:
  - `tip` high t=1..10.
  - `sclk_out` rises at t=2 and t=6, falls at t=4 and t=8.
  - `sample` at t=2 and t=6; `shift` at t=4 only.
  - `last_clk` at t=8; `done` at t=11.
- Mode 3 (`cpol`=1, `cpha`=1), `divider`=0, `char_len`=3:
  - Idle level 1.
  - Edges at t=1..6: falls at odd t, rises at even t.
  - `shift` at t=1, 3, 5; `sample` at t=2, 4, 6.
  - `last_clk` at t=6; `done` at t=8.
- Maximum length, `char_len`=0 with `CNT_LEN`=7, `divider`=0:
  - 256 edges and exactly 128 `sample` pulses.
  - `last_clk` at t=256; `done` at t=258.
- Abort: mode 0, `divider`=3, `char_len`=8, `abort` at t=10:
  - t=11: `tip`=0, `sclk_out`=0, no `done`.
  - A later `go` starts a clean full transfer.
- Ignored changes:
  - `go` and changes to `cpol`/`divider` mid-transfer do not alter edge timing.
  - `go` together with `abort` in IDLE leaves `tip`=0.
- Reset mid-transfer: `wb_rst_n`=0 at t=5 with `cpol`=1 latched.
  - Next cycle all outputs are 0.
  - After release, `sclk_out`=1 after 1 cycle, following live `cpol`=1.
